// File: rtl/avmm_wr_ack_multiplier_if.sv
// Bus bundle for avmm_wr_ack_multiplier: burst-ack input side plus the
// per-beat ack and status outputs. The DUT connects through the slave modport.
`ifndef LOCAL_MEM_BURST_CNT_WIDTH
`define LOCAL_MEM_BURST_CNT_WIDTH 7
`endif

interface avmm_wr_ack_multiplier_if #(
  parameter int unsigned AVMM_BURSTCNT_WIDTH = `LOCAL_MEM_BURST_CNT_WIDTH
);
  logic                           burst_wr_ack;
  logic [AVMM_BURSTCNT_WIDTH-1:0] burst_wr_ack_burstcnt;
  logic                           kernel_avmm_writeack;
  logic                           ack_fifo_almost_full;
  logic                           ack_fifo_overflow;
  logic                           busy;
  logic [31:0]                    beat_ack_count;

  modport master (
    output burst_wr_ack,
    output burst_wr_ack_burstcnt,
    input  kernel_avmm_writeack,
    input  ack_fifo_almost_full,
    input  ack_fifo_overflow,
    input  busy,
    input  beat_ack_count
  );

  modport slave (
    input  burst_wr_ack,
    input  burst_wr_ack_burstcnt,
    output kernel_avmm_writeack,
    output ack_fifo_almost_full,
    output ack_fifo_overflow,
    output busy,
    output beat_ack_count
  );
endinterface

// File: rtl/avmm_wr_ack_multiplier.sv
// avmm_wr_ack_multiplier: turns one burst write-ack (with its burstcount)
// into burstcount single-cycle kernel_avmm_writeack pulses. Pending burst
// acks are queued in a small FIFO; bursts expand back-to-back with no bubble.
// Optional beat statistics counter enabled by macro ASP_WR_ACK_MULT_STATS_EN.
`ifndef LOCAL_MEM_BURST_CNT_WIDTH
`define LOCAL_MEM_BURST_CNT_WIDTH 7
`endif

module avmm_wr_ack_multiplier #(
  parameter int unsigned AVMM_BURSTCNT_WIDTH          = `LOCAL_MEM_BURST_CNT_WIDTH,
  parameter int unsigned ACK_FIFO_DEPTH               = 64,
  parameter int unsigned ACK_FIFO_ALMOSTFULL_THRESHOLD = 4
) (
  input  logic                      kernel_avmm_clk,
  input  logic                      kernel_avmm_reset_n,
  avmm_wr_ack_multiplier_if.slave   avmm_if
);

  localparam int unsigned PTR_W = $clog2(ACK_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ACK_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

  state_t                         r_state, w_state_nxt;
  logic [AVMM_BURSTCNT_WIDTH-1:0] r_beats_left, w_beats_left_nxt;

  logic [AVMM_BURSTCNT_WIDTH-1:0] r_fifo_mem [ACK_FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]               r_count, w_count_nxt, w_free_nxt;
  logic                           r_almost_full, r_overflow;

  logic                           w_full, w_empty, w_push, w_pop;
  logic [AVMM_BURSTCNT_WIDTH-1:0] w_head;

  // Full is judged on the registered occupancy, so a same-cycle pop never
  // frees room for an incoming ack.
  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_push      = avmm_if.burst_wr_ack && !w_full;
  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_free_nxt  = DEPTH_C - w_count_nxt;

  // FIFO storage: no reset needed, validity is tracked by the pointers/count.
  always_ff @(posedge kernel_avmm_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= avmm_if.burst_wr_ack_burstcnt;
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
    if (!kernel_avmm_reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_nxt;
      r_almost_full <= (32'(w_free_nxt) <= ACK_FIFO_ALMOSTFULL_THRESHOLD);
      if (avmm_if.burst_wr_ack && w_full) r_overflow <= 1'b1;
    end
  end

  // FSM state and beat down-counter registers.
  always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
    if (!kernel_avmm_reset_n) begin
      r_state      <= ST_IDLE;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats_left <= w_beats_left_nxt;
    end
  end

  // Next-state: load a new burst from the FIFO head when idle or on the last
  // beat of the current burst; zero-length entries are popped and discarded.
  always_comb begin
    w_state_nxt      = r_state;
    w_beats_left_nxt = r_beats_left;
    w_pop            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_beats_left_nxt = w_head;
            w_state_nxt      = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (r_beats_left > AVMM_BURSTCNT_WIDTH'(1)) begin
          w_beats_left_nxt = r_beats_left - AVMM_BURSTCNT_WIDTH'(1);
        end else if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_beats_left_nxt = w_head;
          end else begin
            w_beats_left_nxt = '0;
            w_state_nxt      = ST_IDLE;
          end
        end else begin
          w_beats_left_nxt = '0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_beats_left_nxt = '0;
        w_state_nxt      = ST_IDLE;
      end
    endcase
  end

  assign avmm_if.kernel_avmm_writeack = (r_state == ST_EXPAND);
  assign avmm_if.ack_fifo_almost_full = r_almost_full;
  assign avmm_if.ack_fifo_overflow    = r_overflow;
  assign avmm_if.busy                 = (r_state == ST_EXPAND) || !w_empty;

`ifdef ASP_WR_ACK_MULT_STATS_EN
  logic [31:0] r_beat_ack_count;

  // Count every beat acknowledged to the kernel; wraps naturally at 2^32.
  always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
    if (!kernel_avmm_reset_n)      r_beat_ack_count <= '0;
    else if (r_state == ST_EXPAND) r_beat_ack_count <= r_beat_ack_count + 32'd1;
  end

  assign avmm_if.beat_ack_count = r_beat_ack_count;
`else
  assign avmm_if.beat_ack_count = '0;
`endif

endmodule

// File: tb/tb_avmm_wr_ack_multiplier.sv
// Directed bench for avmm_wr_ack_multiplier (FIFO depth 4, almost-full
// threshold 1 so the overflow scenario fits in a short run).
module tb_avmm_wr_ack_multiplier;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;
  int exp_beats = 0;

  avmm_wr_ack_multiplier_if #(.AVMM_BURSTCNT_WIDTH(7)) ack_if ();

  avmm_wr_ack_multiplier #(
    .AVMM_BURSTCNT_WIDTH(7),
    .ACK_FIFO_DEPTH(4),
    .ACK_FIFO_ALMOSTFULL_THRESHOLD(1)
  ) dut (
    .kernel_avmm_clk(clk),
    .kernel_avmm_reset_n(rst_n),
    .avmm_if(ack_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // Start of a new cycle: 1 ns after the rising edge, safe to drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef ASP_WR_ACK_MULT_STATS_EN
    return 32'(exp_beats);
`else
    return 32'd0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ack_if.burst_wr_ack = 1'b0;
    ack_if.burst_wr_ack_burstcnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ack_if.kernel_avmm_writeack !== 1'b0) begin n_err++; $display("FAIL reset_writeack got %b want 0", ack_if.kernel_avmm_writeack); end
    n_vec++; if (ack_if.ack_fifo_almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full got %b want 0", ack_if.ack_fifo_almost_full); end
    n_vec++; if (ack_if.ack_fifo_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", ack_if.ack_fifo_overflow); end
    n_vec++; if (ack_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", ack_if.busy); end
    n_vec++; if (ack_if.beat_ack_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %h want 0", ack_if.beat_ack_count); end
    step();
    rst_n = 1'b1;
    exp_beats = 0;
    step();
  endtask

  task automatic test_single();
    logic exp_w, exp_b;
    for (int i = 0; i < 10; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0);
      ack_if.burst_wr_ack_burstcnt = 7'd4;
      @(negedge clk);
      exp_w = (i >= 2 && i <= 5);
      exp_b = (i >= 1 && i <= 5);
      n_vec++; if (ack_if.kernel_avmm_writeack !== exp_w) begin n_err++; $display("FAIL single_writeack cyc %0d got %b want %b", i, ack_if.kernel_avmm_writeack, exp_w); end
      n_vec++; if (ack_if.busy !== exp_b) begin n_err++; $display("FAIL single_busy cyc %0d got %b want %b", i, ack_if.busy, exp_b); end
      if (exp_w) exp_beats++;
    end
    n_vec++; if (ack_if.beat_ack_count !== exp_count()) begin n_err++; $display("FAIL single_count got %h want %h", ack_if.beat_ack_count, exp_count()); end
  endtask

  task automatic test_back_to_back();
    logic exp_w;
    for (int i = 0; i < 10; i++) begin
      step();
      ack_if.burst_wr_ack = (i <= 1);
      ack_if.burst_wr_ack_burstcnt = (i == 0) ? 7'd3 : 7'd2;
      @(negedge clk);
      exp_w = (i >= 2 && i <= 6);
      n_vec++; if (ack_if.kernel_avmm_writeack !== exp_w) begin n_err++; $display("FAIL b2b_writeack cyc %0d got %b want %b", i, ack_if.kernel_avmm_writeack, exp_w); end
      if (exp_w) exp_beats++;
    end
    n_vec++; if (ack_if.beat_ack_count !== exp_count()) begin n_err++; $display("FAIL b2b_count got %h want %h", ack_if.beat_ack_count, exp_count()); end
  endtask

  task automatic test_zero_burst();
    logic exp_b;
    for (int i = 0; i < 6; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0);
      ack_if.burst_wr_ack_burstcnt = 7'd0;
      @(negedge clk);
      exp_b = (i == 1);
      n_vec++; if (ack_if.kernel_avmm_writeack !== 1'b0) begin n_err++; $display("FAIL zero_writeack cyc %0d got %b want 0", i, ack_if.kernel_avmm_writeack); end
      n_vec++; if (ack_if.busy !== exp_b) begin n_err++; $display("FAIL zero_busy cyc %0d got %b want %b", i, ack_if.busy, exp_b); end
    end
    n_vec++; if (ack_if.beat_ack_count !== exp_count()) begin n_err++; $display("FAIL zero_count got %h want %h", ack_if.beat_ack_count, exp_count()); end
  endtask

  task automatic test_overflow();
    logic exp_w, exp_af, exp_ov;
    int total = 0;
    for (int i = 0; i < 76; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0) || (i >= 2 && i <= 6);
      ack_if.burst_wr_ack_burstcnt = (i == 0) ? 7'd64 : 7'd1;
      @(negedge clk);
      exp_w  = (i >= 2 && i <= 69);
      exp_af = (i >= 5 && i <= 66);
      exp_ov = (i >= 7);
      if (ack_if.kernel_avmm_writeack === 1'b1) total++;
      n_vec++; if (ack_if.kernel_avmm_writeack !== exp_w) begin n_err++; $display("FAIL ovf_writeack cyc %0d got %b want %b", i, ack_if.kernel_avmm_writeack, exp_w); end
      n_vec++; if (ack_if.ack_fifo_almost_full !== exp_af) begin n_err++; $display("FAIL ovf_almost_full cyc %0d got %b want %b", i, ack_if.ack_fifo_almost_full, exp_af); end
      n_vec++; if (ack_if.ack_fifo_overflow !== exp_ov) begin n_err++; $display("FAIL ovf_flag cyc %0d got %b want %b", i, ack_if.ack_fifo_overflow, exp_ov); end
      if (exp_w) exp_beats++;
    end
    n_vec++; if (total != 68) begin n_err++; $display("FAIL ovf_total_beats got %0d want 68", total); end
    n_vec++; if (ack_if.beat_ack_count !== exp_count()) begin n_err++; $display("FAIL ovf_count got %h want %h", ack_if.beat_ack_count, exp_count()); end
  endtask

  task automatic test_reset_mid_burst();
    logic exp_w;
    for (int i = 0; i < 4; i++) begin
      step();
      ack_if.burst_wr_ack = (i <= 2);
      ack_if.burst_wr_ack_burstcnt = (i == 0) ? 7'd8 : 7'd1;
      if (i == 3) begin
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (ack_if.kernel_avmm_writeack !== 1'b0) begin n_err++; $display("FAIL rstmid_async_writeack got %b want 0", ack_if.kernel_avmm_writeack); end
        n_vec++; if (ack_if.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_async_busy got %b want 0", ack_if.busy); end
      end else begin
        @(negedge clk);
        exp_w = (i == 2);
        n_vec++; if (ack_if.kernel_avmm_writeack !== exp_w) begin n_err++; $display("FAIL rstmid_pre_writeack cyc %0d got %b want %b", i, ack_if.kernel_avmm_writeack, exp_w); end
      end
    end
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin rst_n = 1'b1; exp_beats = 0; end
      @(negedge clk);
      n_vec++; if (ack_if.kernel_avmm_writeack !== 1'b0) begin n_err++; $display("FAIL rstmid_post_writeack cyc %0d got %b want 0", i, ack_if.kernel_avmm_writeack); end
      n_vec++; if (ack_if.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_post_busy cyc %0d got %b want 0", i, ack_if.busy); end
    end
    n_vec++; if (ack_if.ack_fifo_overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow_cleared got %b want 0", ack_if.ack_fifo_overflow); end
    for (int i = 0; i < 6; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0);
      ack_if.burst_wr_ack_burstcnt = 7'd1;
      @(negedge clk);
      exp_w = (i == 2);
      n_vec++; if (ack_if.kernel_avmm_writeack !== exp_w) begin n_err++; $display("FAIL rstmid_new_writeack cyc %0d got %b want %b", i, ack_if.kernel_avmm_writeack, exp_w); end
      if (exp_w) exp_beats++;
    end
    n_vec++; if (ack_if.beat_ack_count !== exp_count()) begin n_err++; $display("FAIL rstmid_count got %h want %h", ack_if.beat_ack_count, exp_count()); end
  endtask

  task automatic test_stats();
`ifdef ASP_WR_ACK_MULT_STATS_EN
    step();
    force dut.r_beat_ack_count = 32'hFFFF_FFFE;
    step();
    release dut.r_beat_ack_count;
    for (int i = 0; i < 8; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0);
      ack_if.burst_wr_ack_burstcnt = 7'd3;
      @(negedge clk);
    end
    n_vec++; if (ack_if.beat_ack_count !== 32'h0000_0001) begin n_err++; $display("FAIL stats_wrap got %h want 00000001", ack_if.beat_ack_count); end
`else
    for (int i = 0; i < 8; i++) begin
      step();
      ack_if.burst_wr_ack = (i == 0);
      ack_if.burst_wr_ack_burstcnt = 7'd3;
      @(negedge clk);
      n_vec++; if (ack_if.beat_ack_count !== 32'd0) begin n_err++; $display("FAIL stats_tied_zero cyc %0d got %h want 0", i, ack_if.beat_ack_count); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_burst();
    test_overflow();
    test_reset_mid_burst();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avmm_wr_ack_multiplier.md
AVMM_WR_ACK_MULTIPLIER -- requirements
Module: avmm_wr_ack_multiplier

Interface
- REQ-001 Parameter AVMM_BURSTCNT_WIDTH, default LOCAL_MEM_BURST_CNT_WIDTH: width of the per-burst burstcount.
- REQ-002 Parameter ACK_FIFO_DEPTH, default 64: number of pending per-burst acks buffered; power of two, at least 4.
- REQ-003 Parameter ACK_FIFO_ALMOSTFULL_THRESHOLD, default 4: free-entry count at or below which almost-full asserts.
- REQ-004 kernel_avmm_clk  in  1  sole clock; all logic is on its rising edge.
- REQ-005 kernel_avmm_reset_n  in  1  reset, asynchronous assert, active-low.
- REQ-006 burst_wr_ack  in  1  one-cycle pulse: one kernel write burst has been acknowledged.
- REQ-007 burst_wr_ack_burstcnt  in  AVMM_BURSTCNT_WIDTH  beat count of the acknowledged burst; sampled with burst_wr_ack.
- REQ-008 kernel_avmm_writeack  out  1  per-beat write-ack to the kernel system.
- REQ-009 ack_fifo_almost_full  out  1  pending-ack FIFO has at most ACK_FIFO_ALMOSTFULL_THRESHOLD free entries.
- REQ-010 ack_fifo_overflow  out  1  sticky flag: a burst ack was dropped.
- REQ-011 busy  out  1  the FSM is in ST_EXPAND or the FIFO is not empty.
- REQ-012 beat_ack_count  out  32  total beats acknowledged (see Configuration).

Function
- REQ-013 Enqueue: if burst_wr_ack=1 and the FIFO is not full, the block SHALL store {burstcnt} in the FIFO at that edge.
- REQ-014 Full is evaluated before any same-cycle dequeue; burst_wr_ack while full SHALL be dropped and SHALL set ack_fifo_overflow.
- REQ-015 The FIFO entry SHALL be visible at the head in the cycle after it is enqueued.
- REQ-016 FSM states SHALL be ST_IDLE and ST_EXPAND, plus a 'beats_left' down-counter of width AVMM_BURSTCNT_WIDTH.
- REQ-017 ST_IDLE with the FIFO not empty: pop the head.
  - head burstcnt non-zero: beats_left <= burstcnt, next state ST_EXPAND.
  - head burstcnt zero: entry discarded, no ack, stay ST_IDLE.
- REQ-018 kernel_avmm_writeack SHALL equal 1 exactly in cycles where the state register is ST_EXPAND, and SHALL be decoded only from registered state.
- REQ-019 ST_EXPAND with beats_left>1: beats_left decrements by 1 each cycle and the state remains ST_EXPAND.
- REQ-020 ST_EXPAND with beats_left==1 (last beat):
  - FIFO not empty, head burstcnt non-zero: pop, beats_left <= head burstcnt, stay ST_EXPAND; there SHALL be no bubble between bursts.
  - FIFO not empty, head burstcnt zero: pop and discard, go to ST_IDLE.
  - FIFO empty: go to ST_IDLE.
- REQ-021 Latency: a burst_wr_ack with burstcnt=B in cycle N into an empty, idle block SHALL produce kernel_avmm_writeack high in cycles N+2 through N+1+B inclusive.
- REQ-022 The total number of kernel_avmm_writeack cycles SHALL equal the sum of the burstcnt values of all non-dropped acks, in arrival order.
- REQ-023 Simultaneous enqueue and dequeue on a non-full FIFO SHALL both take effect, and the occupancy SHALL stay unchanged.
- REQ-024 ack_fifo_almost_full and busy SHALL be registered or decoded from registered state only.

Reset
- REQ-025 While kernel_avmm_reset_n=0, the block SHALL force:
  - state ST_IDLE;
  - beats_left, FIFO occupancy, kernel_avmm_writeack, ack_fifo_overflow, busy and beat_ack_count to 0;
  - ack_fifo_almost_full to 0.
- REQ-026 Reset asserted mid-ST_EXPAND SHALL abandon the remaining beats and flush all pending entries; no ack SHALL be emitted after reset deassertion until a new burst_wr_ack arrives.
- REQ-027 ack_fifo_overflow SHALL clear only on reset.

Configuration
- REQ-028 Macro ASP_WR_ACK_MULT_STATS_EN defined:
  - beat_ack_count increments by 1 every cycle kernel_avmm_writeack=1;
  - it wraps from 2^32-1 to 0.
- REQ-029 Macro ASP_WR_ACK_MULT_STATS_EN undefined: beat_ack_count SHALL be tied to 0 and no counter logic SHALL be generated; all other behaviour is unchanged.

Verification
- REQ-030 Single ack, burstcnt=4, at cycle 10 with the block idle -> writeack high in cycles 12-15, then low; busy low from cycle 16.
- REQ-031 Acks burstcnt=3 at cycle 10 and burstcnt=2 at cycle 11 -> writeack high continuously for cycles 12-16 (5 beats, no gap).
- REQ-032 Ack burstcnt=0 at cycle 10 -> no writeack; busy high in cycle 11 only; beat_ack_count stays 0.
- REQ-033 ACK_FIFO_DEPTH=4, writeack path held busy by a burstcnt=64 ack; five more burstcnt=1 acks are sent back-to-back:
  - ack_fifo_almost_full asserts as the threshold is reached;
  - the fifth ack is dropped and ack_fifo_overflow=1;
  - the total writeack count is 68.
- REQ-034 Reset asserted during beat 2 of a burstcnt=8 burst, with 2 entries queued -> writeack 0 immediately, and 0 acks after release; the next ack with burstcnt=1 yields exactly 1 writeack at release+2 after its pulse.
- REQ-035 With ASP_WR_ACK_MULT_STATS_EN defined and beat_ack_count preloaded near wrap (force 32'hFFFF_FFFE), a burstcnt=3 ack -> count reads 32'h0000_0001; with the macro undefined -> count reads 0 throughout.
